// File: rtl/mac_rr_arbiter.sv
// Round-robin front end that shares one fixed-point MAC between NUM_REQ
// requesters. A granted requester's A/B beats are forwarded to the MAC.
// The single MAC result (or a timeout error) is returned tagged with the
// requester ID and the number of beats accepted.
module mac_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned DATA_W_A = 16,
  parameter int unsigned DATA_W_B = 16,
  parameter int unsigned RES_W    = 32,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned CNT_W    = 9,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_W_A-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W_B-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         mac_valid_a,
  output logic                         mac_valid_b,
  output logic                         mac_last_a,
  output logic                         mac_last_b,
  output logic [DATA_W_A-1:0]          mac_a,
  output logic [DATA_W_B-1:0]          mac_b,
  input  logic                         mac_ready_a,
  input  logic                         mac_ready_b,
  input  logic [RES_W-1:0]             mac_m_data,
  input  logic                         mac_m_valid,
  output logic                         mac_m_ready,
  output logic [RES_W-1:0]             res_data,
  output logic [ID_W-1:0]              res_id,
  output logic [CNT_W-1:0]             res_beats,
  output logic                         res_err,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         busy
);

  localparam int unsigned   TO_W     = $clog2(TIMEOUT) + 1;
  localparam logic [ID_W:0] NREQ_EXT = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DELIVER} state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant;
  logic [CNT_W-1:0]      beat_cnt;
  logic [TO_W-1:0]       to_cnt;

  logic [2*NUM_REQ-1:0]  rot_valid;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_off;
  logic [ID_W:0]         pick_sum;
  logic [ID_W-1:0]       pick_idx;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_W_A-1:0]   sel_a;
  logic [DATA_W_B-1:0]   sel_b;
  logic                  xfer;
  logic                  timeout_hit;

  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  always_comb begin
    rot_valid  = {req_valid, req_valid} >> rr_ptr;
    pick_found = 1'b0;
    pick_off   = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (rot_valid[i-1]) begin
        pick_found = 1'b1;
        pick_off   = ID_W'(i - 1);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= NREQ_EXT) begin
      pick_sum = pick_sum - NREQ_EXT;
    end
    pick_idx = pick_sum[ID_W-1:0];
  end

  // Select the granted requester's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_a     = req_a[i*DATA_W_A +: DATA_W_A];
        sel_b     = req_b[i*DATA_W_B +: DATA_W_B];
      end
    end
  end

  assign xfer        = (state == STREAM) && sel_valid && mac_ready_a && mac_ready_b;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DELIVER);

  // Next-state decode and combinational outputs toward requesters and MAC.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    mac_valid_a = 1'b0;
    mac_valid_b = 1'b0;
    mac_last_a  = 1'b0;
    mac_last_b  = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    mac_m_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) state_nxt = STREAM;
      end
      STREAM: begin
        mac_valid_a = sel_valid;
        mac_valid_b = sel_valid;
        mac_last_a  = sel_last & sel_valid;
        mac_last_b  = sel_last & sel_valid;
        mac_a       = sel_a;
        mac_b       = sel_b;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant == ID_W'(i)) & mac_ready_a & mac_ready_b;
        end
        if (xfer && sel_last) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        mac_m_ready = 1'b1;
        if (mac_m_valid || timeout_hit) state_nxt = DELIVER;
      end
      DELIVER: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus grant, counters and the registered result fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      to_cnt    <= '0;
      res_data  <= '0;
      res_id    <= '0;
      res_beats <= '0;
      res_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (pick_found) grant <= pick_idx;
        end
        STREAM: begin
          if (xfer) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (sel_last) to_cnt <= '0;
          end
        end
        WAIT_RES: begin
          // A result arriving on the timeout cycle takes precedence.
          if (mac_m_valid) begin
            res_data  <= mac_m_data;
            res_err   <= 1'b0;
            res_id    <= grant;
            res_beats <= beat_cnt;
          end else if (timeout_hit) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_id    <= grant;
            res_beats <= beat_cnt;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DELIVER: begin
          if (res_ready) begin
            rr_ptr   <= (grant == LAST_ID) ? '0 : grant + 1'b1;
            beat_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Bench for mac_rr_arbiter: directed requester streams, a MAC stand-in that
// accumulates A*B, a transaction-level reference model checked every cycle,
// and literal expectations per scenario.
module tb_mac_rr_arbiter;
  localparam int N = 3, WA = 16, WB = 16, RW = 32, IW = 2, CW = 9, TO = 64;

  logic            clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
  logic [N*WA-1:0] req_a = '0;
  logic [N*WB-1:0] req_b = '0;
  logic            mac_valid_a, mac_valid_b, mac_last_a, mac_last_b;
  logic [WA-1:0]   mac_a;
  logic [WB-1:0]   mac_b;
  logic            mac_ready_a = 1'b1, mac_ready_b = 1'b1;
  logic [RW-1:0]   mac_m_data = '0;
  logic            mac_m_valid = 1'b0, mac_m_ready;
  logic [RW-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic [CW-1:0]   res_beats;
  logic            res_err, res_valid, busy;
  logic            res_ready = 1'b1;

  int total = 0, bad = 0;

  mac_rr_arbiter #(.NUM_REQ(N), .DATA_W_A(WA), .DATA_W_B(WB), .RES_W(RW),
                   .ID_W(IW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mac_valid_a(mac_valid_a), .mac_valid_b(mac_valid_b),
    .mac_last_a(mac_last_a), .mac_last_b(mac_last_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_ready_a(mac_ready_a), .mac_ready_b(mac_ready_b),
    .mac_m_data(mac_m_data), .mac_m_valid(mac_m_valid), .mac_m_ready(mac_m_ready),
    .res_data(res_data), .res_id(res_id), .res_beats(res_beats), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-requester beat storage (valid=0 entries are one-cycle bubbles).
  logic          mv[N][64], ml[N][64];
  logic [15:0]   ma[N][64], mb[N][64];
  int            head[N], tail[N];
  logic [N-1:0]  take = '0;

  // MAC stand-in state.
  logic signed [31:0] acc = '0;
  logic          pending = 1'b0, resp_en = 1'b1, drv_m = 1'b0, toggle_b = 1'b0;
  int            cnt = 0, resp_delay = 2, stray_cycles = 0;

  // Observation logs.
  int            dl_n = 0, xn = 0, wait_obs = 0;
  int            dl_id[16], dl_beats[16];
  logic          dl_err[16];
  logic [31:0]   dl_data[16];
  logic [15:0]   xlog[32];

  // Reference model: owner, served-next pointer, phase, beats, wait cycles.
  int            m_mode = 0, m_owner = 0, m_next = 0, m_beats = 0, m_wait = 0;
  logic [31:0]   m_data = '0;
  logic          m_err = 1'b0;

  // Input driver: applies queue heads and MAC handshakes just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (take[k] && head[k] < tail[k]) head[k]++;
      if (head[k] < tail[k]) begin
        req_valid[k]         = mv[k][head[k]];
        req_last[k]          = ml[k][head[k]] & mv[k][head[k]];
        req_a[k*WA +: WA]    = ma[k][head[k]];
        req_b[k*WB +: WB]    = mb[k][head[k]];
      end else begin
        req_valid[k]         = 1'b0;
        req_last[k]          = 1'b0;
        req_a[k*WA +: WA]    = '0;
        req_b[k*WB +: WB]    = '0;
      end
    end
    if (toggle_b) mac_ready_b = ~mac_ready_b;
    else          mac_ready_b = 1'b1;
    if (stray_cycles > 0) begin
      stray_cycles--;
      mac_m_valid = 1'b1;
      mac_m_data  = 32'hDEAD_BEEF;
    end else begin
      mac_m_valid = drv_m;
      mac_m_data  = acc;
    end
  end

  // Compare process: check DUT against the model, then advance bookkeeping and model.
  always @(negedge clk) begin
    logic [N-1:0]       e_rdy;
    logic               e_v, e_l, ov, ol;
    logic [15:0]        e_a, e_b, oa, ob;
    logic signed [31:0] pa, pb;
    int                 c;
    logic               found;

    ov = 1'(req_valid >> m_owner);
    ol = 1'(req_last >> m_owner);
    oa = 16'(req_a >> (WA * m_owner));
    ob = 16'(req_b >> (WB * m_owner));
    e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_a = '0; e_b = '0;
    if (m_mode == 1) begin
      e_v = ov; e_l = ov & ol; e_a = oa; e_b = ob;
      if (mac_ready_a && mac_ready_b) e_rdy = N'(1) << m_owner;
    end
    chk("busy", busy, m_mode != 0);
    chk("req_ready", req_ready, e_rdy);
    chk("mac_valid_last", {mac_valid_a, mac_valid_b, mac_last_a, mac_last_b}, {e_v, e_v, e_l, e_l});
    chk("mac_a", mac_a, e_a);
    chk("mac_b", mac_b, e_b);
    chk("mac_m_ready", mac_m_ready, m_mode == 2);
    chk("res_valid", res_valid, m_mode == 3);
    if (m_mode == 3) begin
      chk("res_data", res_data, m_data);
      chk("res_id", res_id, m_owner);
      chk("res_beats", res_beats, m_beats);
      chk("res_err", res_err, m_err);
    end

    for (int k = 0; k < N; k++)
      take[k] = (head[k] < tail[k]) && (!mv[k][head[k]] || req_ready[k]);

    if (mac_valid_a && mac_ready_a && mac_ready_b) begin
      if (xn < 32) xlog[xn] = mac_a;
      xn++;
      pa = 32'(signed'(mac_a));
      pb = 32'(signed'(mac_b));
      acc = acc + pa * pb;
      if (mac_last_a) begin pending = 1'b1; cnt = resp_delay; end
    end else if (pending && cnt > 0) begin
      cnt--;
    end
    if (mac_m_ready) wait_obs++;
    if (mac_m_valid && mac_m_ready) pending = 1'b0;
    if (res_valid && res_ready) begin
      if (dl_n < 16) begin
        dl_id[dl_n] = res_id; dl_beats[dl_n] = res_beats;
        dl_err[dl_n] = res_err; dl_data[dl_n] = res_data;
      end
      dl_n++;
      acc = '0; pending = 1'b0;
    end
    if (reset) begin acc = '0; pending = 1'b0; end
    drv_m = resp_en && pending && cnt == 0;

    if (reset) begin
      m_mode = 0; m_next = 0; m_beats = 0; m_wait = 0; m_data = '0; m_err = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_next + k) % N;
            if (!found && 1'(req_valid >> c)) begin found = 1'b1; m_owner = c; m_mode = 1; end
          end
        end
        1: if (ov && mac_ready_a && mac_ready_b) begin
          if (m_beats < (1 << CW) - 1) m_beats++;
          if (ol) begin m_mode = 2; m_wait = 0; end
        end
        2: begin
          m_wait++;
          if (mac_m_valid) begin m_data = mac_m_data; m_err = 1'b0; m_mode = 3; end
          else if (m_wait == TO) begin m_data = '0; m_err = 1'b1; m_mode = 3; end
        end
        3: if (res_ready) begin m_mode = 0; m_next = (m_owner + 1) % N; m_beats = 0; end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end
    take = '0;
    tick(1);
    chk("rst_ctl", {busy, res_valid, res_err, req_ready, mac_valid_a, mac_valid_b,
                    mac_last_a, mac_last_b, mac_m_ready}, '0);
    chk("rst_res", {res_data, res_id, res_beats}, '0);
    chk("rst_mac_ab", {mac_a, mac_b}, '0);
    reset = 1'b0;
    xn = 0; dl_n = 0; wait_obs = 0;
  endtask

  task automatic push_vec(input int k, input int n, input logic [15:0] a0,
                          input logic [15:0] astep, input logic [15:0] b);
    for (int i = 0; i < n; i++) begin
      mv[k][tail[k]] = 1'b1;
      ml[k][tail[k]] = (i == n - 1);
      ma[k][tail[k]] = 16'(a0 + astep * i);
      mb[k][tail[k]] = b;
      tail[k]++;
    end
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int c = 0;
    while (dl_n < n && c < budget) begin tick(1); c++; end
    chk("deliveries", dl_n, n);
  endtask

  initial begin
    int c;
    // Single requester 1, A = 1.0..4.0, B = 1.0 in Q8.8; a stray MAC result in IDLE first.
    do_reset();
    stray_cycles = 2;
    tick(3);
    push_vec(1, 4, 16'h0100, 16'h0100, 16'h0100);
    wait_deliv(1, 200);
    chk("t1_id", dl_id[0], 1);
    chk("t1_beats", dl_beats[0], 4);
    chk("t1_err", dl_err[0], 0);
    chk("t1_data", dl_data[0], 32'h000A_0000);

    // All three requesters valid; requester 0 has two vectors queued.
    do_reset();
    push_vec(0, 2, 16'h1001, 16'h0001, 16'h0100);
    push_vec(0, 2, 16'h1101, 16'h0001, 16'h0100);
    push_vec(1, 2, 16'h2001, 16'h0001, 16'h0100);
    push_vec(2, 2, 16'h3001, 16'h0001, 16'h0100);
    wait_deliv(4, 400);
    chk("t2_order0", dl_id[0], 0);
    chk("t2_order1", dl_id[1], 1);
    chk("t2_order2", dl_id[2], 2);
    chk("t2_order3", dl_id[3], 0);
    chk("t2_beats", dl_beats[3], 2);

    // mac_ready_b toggling during a six-beat stream.
    do_reset();
    toggle_b = 1'b1;
    push_vec(2, 6, 16'h0100, 16'h0100, 16'h0100);
    wait_deliv(1, 300);
    toggle_b = 1'b0;
    chk("t3_beats", dl_beats[0], 6);
    chk("t3_xfers", xn, 6);
    for (int i = 0; i < 6; i++) chk("t3_xfer_a", xlog[i], 16'(256 * (i + 1)));
    chk("t3_data", dl_data[0], 32'h0015_0000);

    // MAC never answers: timeout after 64 cycles, then a normal vector.
    do_reset();
    resp_en = 1'b0;
    push_vec(0, 1, 16'h0200, 16'h0000, 16'h0300);
    wait_deliv(1, 200);
    chk("t4_err", dl_err[0], 1);
    chk("t4_data", dl_data[0], 32'h0);
    chk("t4_wait_cycles", wait_obs, 64);
    chk("t4_beats", dl_beats[0], 1);
    resp_en = 1'b1;
    push_vec(1, 2, 16'h0100, 16'h0100, 16'h0100);
    wait_deliv(2, 200);
    chk("t4_next_id", dl_id[1], 1);
    chk("t4_next_err", dl_err[1], 0);
    chk("t4_next_data", dl_data[1], 32'h0003_0000);

    // Result held while res_ready is low; competing requester must wait.
    do_reset();
    res_ready = 1'b0;
    push_vec(0, 2, 16'h0400, 16'h0001, 16'h0100);
    push_vec(1, 2, 16'h0500, 16'h0001, 16'h0100);
    c = 0;
    while (!res_valid && c < 100) begin tick(1); c++; end
    chk("t5_res_valid_seen", res_valid, 1);
    tick(10);
    chk("t5_hold_valid", res_valid, 1);
    chk("t5_hold_fields", {res_data, res_id, res_beats, res_err},
        {32'h0008_0100, 2'd0, 9'd2, 1'b0});
    chk("t5_no_grant", req_ready, '0);
    res_ready = 1'b1;
    wait_deliv(2, 200);
    chk("t5_id0", dl_id[0], 0);
    chk("t5_id1", dl_id[1], 1);

    // Reset during a stream: vector abandoned, pointer back to 0.
    do_reset();
    push_vec(1, 1, 16'h0100, 16'h0000, 16'h0100);
    wait_deliv(1, 100);
    push_vec(0, 6, 16'h0100, 16'h0100, 16'h0100);
    c = 0;
    while (xn < 4 && c < 100) begin tick(1); c++; end
    chk("t6_beats_before_reset", xn >= 4, 1);
    do_reset();
    tick(20);
    chk("t6_no_abandoned_result", dl_n, 0);
    push_vec(2, 1, 16'h0700, 16'h0000, 16'h0100);
    push_vec(1, 1, 16'h0600, 16'h0000, 16'h0100);
    wait_deliv(2, 200);
    chk("t6_first_id", dl_id[0], 1);
    chk("t6_second_id", dl_id[1], 2);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_rr_arbiter.md
Name: mac_rr_arbiter

Overview:
- Shares one fixed-point MAC between NUM_REQ requesters.
- Each requester submits a paired A/B vector stream, terminated by a last flag.
- The arbiter grants one requester at a time in round-robin order and forwards its beats to the MAC's A/B slave ports.
- It then collects the single MAC result and returns it on a result stream tagged with the requester ID, the beat count and an error flag.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W_A, 16, A operand width (int_width_a + frac_width_a).
- DATA_W_B, 16, B operand width (int_width_b + frac_width_b).
- RES_W, 32, MAC result width (int_width_out + frac_width_out).
- ID_W, 2, requester ID width; must satisfy ceil(log2(NUM_REQ)) ≤ ID_W.
- CNT_W, 9, beat counter width (matches MAC additional_bits).
- TIMEOUT, 64, max cycles in WAIT_RES before the error path is taken.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last beat of vector.
- req_a  in  NUM_REQ*DATA_W_A  packed A operands; requester i at [i*DATA_W_A +: DATA_W_A].
- req_b  in  NUM_REQ*DATA_W_B  packed B operands, same packing.
- req_ready  out  NUM_REQ  per-requester beat accept.
- mac_valid_a  out  1  to MAC s_valid_a.
- mac_valid_b  out  1  to MAC s_valid_b.
- mac_last_a  out  1  to MAC s_last_a.
- mac_last_b  out  1  to MAC s_last_b.
- mac_a  out  DATA_W_A  to MAC A_in.
- mac_b  out  DATA_W_B  to MAC B_in.
- mac_ready_a  in  1  from MAC s_ready_a.
- mac_ready_b  in  1  from MAC s_ready_b.
- mac_m_data  in  RES_W  from MAC m_data.
- mac_m_valid  in  1  from MAC m_valid.
- mac_m_ready  out  1  to MAC m_ready.
- res_data  out  RES_W  result value.
- res_id  out  ID_W  requester that owns the result.
- res_beats  out  CNT_W  beats accepted for this vector.
- res_err  out  1  timeout occurred; res_data is 0.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer accept.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset** (sampled on clk while reset=1):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, to_cnt=0.
  - All outputs 0: req_ready, mac_valid_a/b, mac_last_a/b, mac_a, mac_b, mac_m_ready, res_*, busy.
  - Reset mid-operation abandons the vector and any pending result. No partial result is emitted.
- **States:** IDLE, STREAM, WAIT_RES, DELIVER.
- **IDLE:**
  - If any req_valid is high, pick the first set bit scanning from rr_ptr upward with wrap. Register it in grant and go to STREAM next cycle.
  - Arbitration takes 1 cycle. No beat is accepted in IDLE. req_ready=0.
- **STREAM:**
  - Combinational forwarding from requester g=grant:
    - mac_valid_a = mac_valid_b = req_valid[g].
    - mac_last_a = mac_last_b = req_last[g] & req_valid[g].
    - mac_a = req_a[g], mac_b = req_b[g].
  - req_ready[g] = mac_ready_a & mac_ready_b; req_ready of all other requesters = 0.
  - A beat transfers when req_valid[g] & mac_ready_a & mac_ready_b. On transfer, beat_cnt += 1, saturating at all-ones.
  - A transfer with req_last[g] → WAIT_RES, with to_cnt cleared.
  - Bubbles (req_valid[g]=0) hold STREAM indefinitely. The grant is not revoked.
- **WAIT_RES:**
  - mac_m_ready=1; MAC inputs driven 0 (valid/last 0).
  - mac_m_valid=1 → capture mac_m_data into res_data, res_err=0 → DELIVER.
  - Otherwise to_cnt += 1. When to_cnt reaches TIMEOUT-1 without mac_m_valid → res_data=0, res_err=1 → DELIVER.
  - mac_m_valid in the same cycle as the timeout wins: the result is captured and res_err=0.
- **DELIVER:**
  - res_valid=1; res_id=grant and res_beats=beat_cnt are registered.
  - res_data, res_id, res_beats and res_err are held stable while res_valid & !res_ready.
  - res_valid & res_ready → res_valid=0, rr_ptr=(grant+1) mod NUM_REQ, beat_cnt=0 → IDLE.
- **Fairness:** the requester just served has lowest priority in the next arbitration. All NUM_REQ requesters continuously valid ⇒ grants 0,1,2,0,...
- **Latency:**
  - Requester first valid to first req_ready = 2 cycles (IDLE arbitration + STREAM), given the MAC is ready.
  - Result valid to res_valid = 1 cycle.
- **Stray MAC result:** mac_m_valid outside WAIT_RES is ignored and mac_m_ready=0.

Test Plan:
- Single requester 1, 4 beats A={1.0,2.0,3.0,4.0}, B=1.0 (Q8.8 0x0100…), MAC returns 10.0 → res_id=1, res_beats=4, res_err=0, res_data=mac_m_data; req_ready[0,2] never high.
- All 3 requesters valid with 2-beat vectors back-to-back, res_ready=1 → grant order 0,1,2,0; each res_id matches; no beat of requester k reaches mac_a while grant≠k.
- mac_ready_b toggles 0/1 each cycle during a 6-beat stream → exactly 6 transfers, res_beats=6, no duplicate or lost beat on mac_a.
- MAC never asserts mac_m_valid after last → after TIMEOUT=64 cycles in WAIT_RES, res_err=1, res_data=0; next arbitration proceeds normally.
- res_ready held 0 for 10 cycles in DELIVER → res_valid stays 1 and res_data/res_id/res_beats stable; no new grant until acceptance.
- reset=1 for one cycle mid-STREAM at beat 3 → next cycle all outputs 0, state IDLE, rr_ptr=0; no res_valid for the abandoned vector.
